// File: rtl/raizing_mix_pkg.sv
// raizing_mix_pkg
//   Shared definitions for the N-layer priority mixer.
//   - DEF_* localparams: default field widths and layer count.
//   - is_opaque(): transparency test on one layer's colour (low bits all
//     zero or layer disabled -> transparent).
//   - level_count(): number of candidates present at a given tree level.
//   The candidate record {opaque, prio, colour, id} is declared in the top
//   level, because its field widths follow the top level's parameters.
package raizing_mix_pkg;

  localparam int DEF_NUM_LAYERS = 5;
  localparam int DEF_PRIO_W     = 4;
  localparam int DEF_COLOR_W    = 11;
  localparam int DEF_TRANS_W    = 4;
  localparam int MAX_COLOR_W    = 32;

  // Opaque when the layer is enabled and its low trans_w colour bits are
  // not all zero.
  function automatic logic is_opaque(input logic en,
                                     input logic [MAX_COLOR_W-1:0] colour,
                                     input int trans_w);
    logic [MAX_COLOR_W-1:0] mask;
    mask = (MAX_COLOR_W'(1) << trans_w) - MAX_COLOR_W'(1);
    return en && ((colour & mask) != '0);
  endfunction

  // Candidates remaining after 'level' pairwise reductions of n inputs.
  function automatic int level_count(input int n, input int level);
    int c;
    c = n;
    for (int k = 0; k < level; k++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/raizing_mix_node.sv
// raizing_mix_node
//   One registered two-input compare node of the mixer tree.
//   Candidate vector layout (MSB first): {opaque, prio[PRIO_W], payload[PAY_W]}.
//   'a' always comes from the lower-numbered layers, so a tie on priority
//   goes to 'a'.
// Ports:
//   clk, reset (sync, active-high), cen (pipeline enable)
//   a, b : candidates in;  y : registered winner
module raizing_mix_node #(
  parameter int PRIO_W = 4,
  parameter int PAY_W  = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cen,
  input  logic [PRIO_W+PAY_W:0]   a,
  input  logic [PRIO_W+PAY_W:0]   b,
  output logic [PRIO_W+PAY_W:0]   y
);

  localparam int CAND_W = 1 + PRIO_W + PAY_W;

  logic a_wins;

  // b only wins when it is opaque and either a is transparent or b's
  // priority is strictly larger. Two transparent inputs yield a, which is
  // itself transparent.
  always_comb begin
    a_wins = !b[CAND_W-1] ||
             (a[CAND_W-1] && (a[CAND_W-2 -: PRIO_W] >= b[CAND_W-2 -: PRIO_W]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y <= '0;
    end else if (cen) begin
      y <= a_wins ? a : b;
    end
  end

endmodule

// File: rtl/raizing_layer_mixer.sv
// raizing_layer_mixer
//   Pipelined N-layer priority mixer. Stage 0 registers one candidate per
//   layer, a registered pairwise tree of raizing_mix_node picks the winner,
//   and the output register applies background and blanking.
//   Latency: $clog2(NUM_LAYERS)+2 PIXEL_CEN strobes. All registers hold
//   between strobes.
// Ports:
//   CLK, RESET (sync, active-high), PIXEL_CEN (pipeline enable)
//   ACTIVE        display-on for the presented pixel
//   LAYER_PIXELS  layer i at [i*PIX_W +: PIX_W], field {prio, colour}
//   LAYER_EN      per-layer enable (0 -> transparent)
//   BG_COLOR      index used when no layer is opaque
//   FINAL_PIXEL   mixed palette index (0 while blanked)
//   ACTIVE_OUT    ACTIVE aligned with FINAL_PIXEL
//   WIN_LAYER     winning layer id, NUM_LAYERS for background
//                 (present only with RAIZING_MIXER_LAYER_ID_EN defined)
module raizing_layer_mixer
  import raizing_mix_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int PRIO_W     = DEF_PRIO_W,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int TRANS_W    = DEF_TRANS_W
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   PIXEL_CEN,
  input  logic                                   ACTIVE,
  input  logic [NUM_LAYERS*(PRIO_W+COLOR_W)-1:0] LAYER_PIXELS,
  input  logic [NUM_LAYERS-1:0]                  LAYER_EN,
  input  logic [COLOR_W-1:0]                     BG_COLOR,
  output logic [COLOR_W-1:0]                     FINAL_PIXEL,
`ifdef RAIZING_MIXER_LAYER_ID_EN
  output logic [$clog2(NUM_LAYERS+1)-1:0]        WIN_LAYER,
`endif
  output logic                                   ACTIVE_OUT
);

  localparam int PIX_W = PRIO_W + COLOR_W;
  localparam int DEPTH = $clog2(NUM_LAYERS);
`ifdef RAIZING_MIXER_LAYER_ID_EN
  localparam int ID_W  = $clog2(NUM_LAYERS + 1);
  localparam int PAY_W = COLOR_W + ID_W;
`else
  localparam int PAY_W = COLOR_W;
`endif
  localparam int CAND_W = 1 + PRIO_W + PAY_W;

  typedef struct packed {
    logic               opaque;
    logic [PRIO_W-1:0]  prio;
    logic [COLOR_W-1:0] colour;
`ifdef RAIZING_MIXER_LAYER_ID_EN
    logic [ID_W-1:0]    id;
`endif
  } cand_t;

  cand_t              cand_in [NUM_LAYERS];
  cand_t              stage0  [NUM_LAYERS];
  logic [CAND_W-1:0]  tree    [DEPTH+1][NUM_LAYERS];
  logic               act_p   [DEPTH+1];
  logic [COLOR_W-1:0] bg_p    [DEPTH+1];

  // Stage 0 candidate formation.
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cand_in[i].prio   = LAYER_PIXELS[i*PIX_W + COLOR_W +: PRIO_W];
      cand_in[i].colour = LAYER_PIXELS[i*PIX_W +: COLOR_W];
      cand_in[i].opaque = is_opaque(LAYER_EN[i],
                                    MAX_COLOR_W'(LAYER_PIXELS[i*PIX_W +: COLOR_W]),
                                    TRANS_W);
`ifdef RAIZING_MIXER_LAYER_ID_EN
      cand_in[i].id     = ID_W'(i);
`endif
    end
  end

  // Stage 0 registers plus the ACTIVE / BG_COLOR delay line that follows
  // the candidates through the tree.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_LAYERS; i++) stage0[i] <= '0;
      for (int k = 0; k <= DEPTH; k++) begin
        act_p[k] <= 1'b0;
        bg_p[k]  <= '0;
      end
    end else if (PIXEL_CEN) begin
      for (int i = 0; i < NUM_LAYERS; i++) stage0[i] <= cand_in[i];
      act_p[0] <= ACTIVE;
      bg_p[0]  <= BG_COLOR;
      for (int k = 1; k <= DEPTH; k++) begin
        act_p[k] <= act_p[k-1];
        bg_p[k]  <= bg_p[k-1];
      end
    end
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_lvl0
    assign tree[0][i] = stage0[i];
  end

  // Reduction tree. An odd leftover candidate is paired with an all-zero
  // (transparent) partner so it passes through with the same register delay.
  for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
    localparam int CNT_IN  = level_count(NUM_LAYERS, l);
    localparam int CNT_OUT = level_count(NUM_LAYERS, l + 1);
    for (genvar j = 0; j < NUM_LAYERS; j++) begin : g_slot
      if (j < CNT_OUT) begin : g_node
        logic [CAND_W-1:0] b_in;
        if (2*j + 1 < CNT_IN) begin : g_pair
          assign b_in = tree[l][2*j+1];
        end else begin : g_odd
          assign b_in = '0;
        end
        raizing_mix_node #(
          .PRIO_W (PRIO_W),
          .PAY_W  (PAY_W)
        ) u_node (
          .clk   (CLK),
          .reset (RESET),
          .cen   (PIXEL_CEN),
          .a     (tree[l][2*j]),
          .b     (b_in),
          .y     (tree[l+1][j])
        );
      end else begin : g_unused
        assign tree[l+1][j] = '0;
      end
    end
  end

  // Output register: blanking first, then background vs winner.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FINAL_PIXEL <= '0;
      ACTIVE_OUT  <= 1'b0;
`ifdef RAIZING_MIXER_LAYER_ID_EN
      WIN_LAYER   <= '0;
`endif
    end else if (PIXEL_CEN) begin
      ACTIVE_OUT <= act_p[DEPTH];
      if (!act_p[DEPTH]) begin
        FINAL_PIXEL <= '0;
      end else if (tree[DEPTH][0][CAND_W-1]) begin
        FINAL_PIXEL <= tree[DEPTH][0][PAY_W-1 -: COLOR_W];
      end else begin
        FINAL_PIXEL <= bg_p[DEPTH];
      end
`ifdef RAIZING_MIXER_LAYER_ID_EN
      if (!act_p[DEPTH]) begin
        WIN_LAYER <= '0;
      end else if (tree[DEPTH][0][CAND_W-1]) begin
        WIN_LAYER <= tree[DEPTH][0][ID_W-1:0];
      end else begin
        WIN_LAYER <= ID_W'(NUM_LAYERS);
      end
`endif
    end
  end

endmodule
